// File: rtl/set_pkg.sv
// Shared constants, widths and FSM encoding for the SET host controller.
package set_pkg;

    localparam logic [1:0] MODE_A   = 2'd0;
    localparam logic [1:0] MODE_AB  = 2'd1;
    localparam logic [1:0] MODE_XOR = 2'd2;
    localparam logic [1:0] MODE_3   = 2'd3;

    localparam int CENTRAL_W = 24;
    localparam int RADIUS_W  = 12;
    localparam int CAND_W    = 8;

    localparam logic [CAND_W-1:0] TIMEOUT_CODE = 8'hFF;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        ARM,
        WAIT,
        HOLD
    } state_t;

endpackage

// File: rtl/set_req_fifo.sv
// Synchronous request FIFO with registered full/empty flags and an occupancy count.
module set_req_fifo #(
    parameter int WIDTH = 42,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;
    logic [CW-1:0]    count_next;

    assign do_push    = push && !full;
    assign do_pop     = pop && (count != '0);
    assign count_next = count + CW'(do_push) - CW'(do_pop);
    assign rdata      = mem[rd_ptr];

    // full tracks the next count so no overflow push slips through; empty
    // follows the current count, so a fresh entry is seen one cycle later
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count_next;
            full  <= (count_next == FULL_COUNT);
            empty <= (count == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/set_host_ctrl.sv
// Buffered job initiator for the SET engine: queues jobs, issues one at a time, returns tagged results.
// Optional macro SET_TIMEOUT_EN adds a WAIT-state watchdog that posts a timeout result.
module set_host_ctrl
    import set_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TAG_W   = 4,
    parameter int TIMEOUT = 1023
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [CENTRAL_W-1:0] req_central,
    input  logic [RADIUS_W-1:0]  req_radius,
    input  logic [1:0]           req_mode,
    input  logic [TAG_W-1:0]     req_tag,
    output logic                 set_en,
    output logic [CENTRAL_W-1:0] set_central,
    output logic [RADIUS_W-1:0]  set_radius,
    output logic [1:0]           set_mode,
    input  logic                 set_busy,
    input  logic                 set_valid,
    input  logic [CAND_W-1:0]    set_candidate,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [CAND_W-1:0]    res_candidate,
    output logic [TAG_W-1:0]     res_tag,
    output logic                 res_timeout
);

    localparam int ENTRY_W = CENTRAL_W + RADIUS_W + 2 + TAG_W;

    state_t                 state;
    state_t                 state_next;
    logic [ENTRY_W-1:0]     head;
    logic [$clog2(DEPTH):0] fifo_count;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   head_ok;
    logic                   pop;
    logic                   expired;
    logic [TAG_W-1:0]       job_tag;

    set_req_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (req_valid),
        .pop   (pop),
        .wdata ({req_central, req_radius, req_mode, req_tag}),
        .rdata (head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign req_ready = !fifo_full;
    assign head_ok   = !fifo_empty && (fifo_count != '0);
    assign set_en    = (state == ISSUE);

`ifdef SET_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT + 1);
    logic [TMR_W-1:0] timer;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer <= '0;
        end else if (state == ISSUE) begin
            timer <= '0;
        end else if (state == WAIT) begin
            timer <= timer + 1'b1;
        end
    end

    assign expired = (state == WAIT) && (timer == TMR_W'(TIMEOUT - 1));

    // A real result in the expiry cycle wins over the timeout
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_timeout <= 1'b0;
        end else if ((state == WAIT) && (set_valid || expired)) begin
            res_timeout <= !set_valid;
        end
    end
`else
    assign expired     = 1'b0;
    assign res_timeout = 1'b0;
`endif

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (head_ok && !set_busy && !res_valid) begin
                    pop        = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE:   state_next = ARM;
            ARM:     state_next = WAIT;
            WAIT:    if (set_valid || expired) state_next = HOLD;
            HOLD:    if (!set_busy) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Operands are presented only for the ISSUE cycle and zero otherwise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            set_central <= '0;
            set_radius  <= '0;
            set_mode    <= '0;
            job_tag     <= '0;
        end else if (pop) begin
            {set_central, set_radius, set_mode, job_tag} <= head;
        end else if (state == ISSUE) begin
            set_central <= '0;
            set_radius  <= '0;
            set_mode    <= '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_valid     <= 1'b0;
            res_candidate <= '0;
            res_tag       <= '0;
        end else if ((state == WAIT) && (set_valid || expired)) begin
            res_valid     <= 1'b1;
            res_candidate <= set_valid ? set_candidate : TIMEOUT_CODE;
            res_tag       <= job_tag;
        end else if (res_valid && res_ready) begin
            res_valid <= 1'b0;
        end
    end

endmodule
